// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: registered request arbiter with a run-time choice of
// fixed priority (highest index wins) or round-robin (rotating pointer).
//
// Handshake: a grant is offered while gnt_valid_o = 1 and is consumed on a
// rising edge where gnt_valid_o = 1 and gnt_ready_i = 1. While it is not
// consumed, gnt_idx_o / gnt_onehot_o are held stable. On a consuming edge a
// new winner may be loaded in the same cycle, which gives one grant per cycle.
module priority_arbiter_rr #(
    parameter int  NUM_REQ = 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               mode_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               gnt_ready_i,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic [NUM_REQ-1:0] gnt_onehot_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               state_q;
    logic                 gnt_valid_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic [NUM_REQ-1:0]   gnt_onehot_q;
    logic [IDX_W-1:0]     ptr_q;

    logic                 handshake;
    logic                 arb_go;
    logic [IDX_W-1:0]     idx_inc;
    logic [IDX_W-1:0]     rr_base;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 rr_found;
    int                   rr_off;
    int                   rr_sum;
    logic [IDX_W-1:0]     rr_idx;
    logic [IDX_W-1:0]     fix_idx;
    logic [IDX_W-1:0]     win_idx_d;
    logic [NUM_REQ-1:0]   win_onehot_d;

    // Arbitration: both winners are computed every cycle, mode_i selects one.
    // On a round-robin handshake the search starts from the already-advanced
    // pointer, so the requester just served drops to lowest priority.
    always_comb begin
        handshake = (state_q == ST_GRANT) && gnt_ready_i;
        arb_go    = enable_i && (|req_i);
        idx_inc   = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
        rr_base   = (handshake && mode_i) ? idx_inc : ptr_q;

        // Fixed priority: last set bit in ascending scan is the highest index.
        fix_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[i]) begin
                fix_idx = IDX_W'(i);
            end
        end

        // Round-robin: rotate so rr_base lands at bit 0, take the lowest set
        // bit, then map the offset back to an absolute index with wrap.
        req_rot  = NUM_REQ'({req_i, req_i} >> rr_base);
        rr_found = 1'b0;
        rr_off   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rr_found && req_rot[i]) begin
                rr_found = 1'b1;
                rr_off   = i;
            end
        end
        rr_sum = int'(rr_base) + rr_off;
        if (rr_sum >= NUM_REQ) begin
            rr_sum = rr_sum - NUM_REQ;
        end
        rr_idx = IDX_W'(rr_sum);

        win_idx_d    = mode_i ? rr_idx : fix_idx;
        win_onehot_d = '0;
        win_onehot_d[win_idx_d] = 1'b1;
    end

    // Grant FSM with registered outputs and the round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            ptr_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_go) begin
                        state_q      <= ST_GRANT;
                        gnt_valid_q  <= 1'b1;
                        gnt_idx_q    <= win_idx_d;
                        gnt_onehot_q <= win_onehot_d;
                    end
                end
                ST_GRANT: begin
                    if (gnt_ready_i) begin
                        if (mode_i) begin
                            ptr_q <= idx_inc;
                        end
                        if (arb_go) begin
                            gnt_valid_q  <= 1'b1;
                            gnt_idx_q    <= win_idx_d;
                            gnt_onehot_q <= win_onehot_d;
                        end else begin
                            state_q      <= ST_IDLE;
                            gnt_valid_q  <= 1'b0;
                            gnt_idx_q    <= '0;
                            gnt_onehot_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    gnt_valid_q  <= 1'b0;
                    gnt_idx_q    <= '0;
                    gnt_onehot_q <= '0;
                end
            endcase
        end
    end

    assign gnt_valid_o  = gnt_valid_q;
    assign gnt_idx_o    = gnt_idx_q;
    assign gnt_onehot_o = gnt_onehot_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed bench for priority_arbiter_rr (NUM_REQ = 8): reset, round-robin
// sweep and wrap, fixed-priority hold, enable gating, reset mid-grant.
module tb_priority_arbiter_rr;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             enable_i;
    logic             mode_i;
    logic [N-1:0]     req_i;
    logic             gnt_ready_i;
    logic             gnt_valid_o;
    logic [IDX_W-1:0] gnt_idx_o;
    logic [N-1:0]     gnt_onehot_o;

    int total = 0;
    int bad   = 0;

    priority_arbiter_rr #(.NUM_REQ(N)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .mode_i       (mode_i),
        .req_i        (req_i),
        .gnt_ready_i  (gnt_ready_i),
        .gnt_valid_o  (gnt_valid_o),
        .gnt_idx_o    (gnt_idx_o),
        .gnt_onehot_o (gnt_onehot_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Compare all three grant outputs against the hand-computed expectation.
    task automatic check(input string tag, input logic exp_v, input logic [IDX_W-1:0] exp_idx);
        logic [N-1:0]     exp_oh;
        logic [IDX_W-1:0] exp_i;
        exp_oh = '0;
        exp_i  = exp_v ? exp_idx : '0;
        if (exp_v) exp_oh[exp_idx] = 1'b1;

        total++;
        assert (gnt_valid_o === exp_v) else begin
            bad++;
            $error("FAIL %s valid: observed=%0b expected=%0b", tag, gnt_valid_o, exp_v);
        end
        total++;
        assert (gnt_idx_o === exp_i) else begin
            bad++;
            $error("FAIL %s idx: observed=%0d expected=%0d", tag, gnt_idx_o, exp_i);
        end
        total++;
        assert (gnt_onehot_o === exp_oh) else begin
            bad++;
            $error("FAIL %s onehot: observed=%h expected=%h", tag, gnt_onehot_o, exp_oh);
        end
    endtask

    initial begin
        // Reset held for two edges with every request raised
        rst_ni = 1'b0; enable_i = 1'b1; mode_i = 1'b1; req_i = 8'hFF; gnt_ready_i = 1'b1;
        #2;
        tick(); check("reset_0", 1'b0, 3'd0);
        tick(); check("reset_1", 1'b0, 3'd0);

        // First RR grant after reset starts at pointer 0
        rst_ni = 1'b1;
        tick(); check("rr_first", 1'b1, 3'd0);

        // RR sweep: one grant per cycle, 1..7 then wrap to 0
        for (int k = 1; k <= 8; k++) begin
            tick(); check($sformatf("rr_sweep_%0d", k), 1'b1, IDX_W'(k % 8));
        end

        // Serve idx 0 (ptr->1), lone requester 6 wins
        req_i = 8'h40;
        tick(); check("rr_to6", 1'b1, 3'd6);
        // Handshake on 6 (ptr->7); search 7 then wrap to 0
        req_i = 8'h41;
        tick(); check("rr_wrap0", 1'b1, 3'd0);
        // Handshake on 0 (ptr->1); 6 is next above 1
        tick(); check("rr_after_wrap6", 1'b1, 3'd6);

        // Handshake on 6 with no requests: back to idle (ptr->7)
        req_i = 8'h00;
        tick(); check("no_req_idle", 1'b0, 3'd0);

        // Fixed priority: 0x26 -> highest set bit is 5
        mode_i = 1'b0; req_i = 8'h26; gnt_ready_i = 1'b0;
        tick(); check("fixed_26", 1'b1, 3'd5);
        req_i = 8'h01;
        tick(); check("fixed_hold_0", 1'b1, 3'd5);
        mode_i = 1'b1;
        tick(); check("fixed_hold_1", 1'b1, 3'd5);
        mode_i = 1'b0;
        tick(); check("fixed_hold_2", 1'b1, 3'd5);
        gnt_ready_i = 1'b1;
        tick(); check("fixed_next0", 1'b1, 3'd0);

        // Fixed-mode handshakes leave ptr at 7: next RR grant from idle is 7
        req_i = 8'h00;
        tick(); check("fixed_idle", 1'b0, 3'd0);
        mode_i = 1'b1; req_i = 8'hFF; gnt_ready_i = 1'b0;
        tick(); check("rr_ptr_kept7", 1'b1, 3'd7);

        // Dropping enable does not withdraw a pending grant
        enable_i = 1'b0;
        tick(); check("dis_hold", 1'b1, 3'd7);
        // Handshake while disabled: grant completes, then idle (ptr->0)
        gnt_ready_i = 1'b1;
        tick(); check("dis_complete", 1'b0, 3'd0);
        req_i = 8'h10; gnt_ready_i = 1'b0;
        tick(); check("dis_gate_0", 1'b0, 3'd0);
        tick(); check("dis_gate_1", 1'b0, 3'd0);

        // Lone requesters win regardless of ptr
        enable_i = 1'b1; gnt_ready_i = 1'b1;
        tick(); check("lone_4", 1'b1, 3'd4);
        req_i = 8'h08;
        tick(); check("lone_3", 1'b1, 3'd3);   // handshake on 4 moved ptr to 5
        gnt_ready_i = 1'b0;
        tick(); check("pre_reset_hold", 1'b1, 3'd3);

        // Reset overrides a pending handshake and clears the pointer
        rst_ni = 1'b0; gnt_ready_i = 1'b1; req_i = 8'hFF;
        tick(); check("mid_reset", 1'b0, 3'd0);
        rst_ni = 1'b1; gnt_ready_i = 1'b0;
        tick(); check("post_reset_ptr0", 1'b1, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
